// File: rtl/uart_spi_pkg.sv
// Shared definitions for the UART-to-SPI bridge.
//   DATA_W_DEF : default byte width
//   state_t    : bridge sequencer states
package uart_spi_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT_SPI,
    ST_SEND,
    ST_WAIT_UART
  } state_t;

endpackage

// File: rtl/byte_fifo.sv
// Circular byte FIFO, DEPTH entries (power of two).
//   clk, reset : clock, async active-high reset (drops all contents)
//   push, din  : write request and data (accepted if not full, or if a pop
//                happens in the same cycle)
//   pop, dout  : read request and head-of-queue data (dout is combinational)
//   full/empty : occupancy flags
//   count      : occupancy, 0..DEPTH
module byte_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr, rptr;
  logic              do_push, do_pop;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign dout    = mem[rptr];
  assign do_pop  = pop && !empty;
  // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (do_push) wptr <= wptr + PTR_ONE;
      if (do_pop)  rptr <= rptr + PTR_ONE;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: count/pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/uart_spi_bridge.sv
// Bridges received UART bytes to an SPI engine and returns each SPI reply
// byte through the UART transmitter.
//   clk, reset            : clock, async active-high reset
//   rx_data, rx_valid     : incoming UART bytes (queued in a FIFO)
//   spi_ready/start/done  : SPI engine handshake; spi_tx_data out, spi_rx_data in
//   uart_tx_ready/start   : UART transmitter handshake; uart_tx_data out
//   ovf_clr, overflow     : sticky dropped-byte flag and its clear
//   fifo_count            : FIFO occupancy
module uart_spi_bridge
  import uart_spi_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_W-1:0]      rx_data,
  input  logic                   rx_valid,
  input  logic                   spi_ready,
  output logic                   spi_start,
  output logic [DATA_W-1:0]      spi_tx_data,
  input  logic                   spi_done,
  input  logic [DATA_W-1:0]      spi_rx_data,
  input  logic                   uart_tx_ready,
  output logic                   uart_tx_start,
  output logic [DATA_W-1:0]      uart_tx_data,
  input  logic                   ovf_clr,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] fifo_count
);

  state_t            state, state_next;
  logic [DATA_W-1:0] fifo_head;
  logic              fifo_full, fifo_empty;
  logic              pop, load_rx, spi_start_d, uart_start_d, drop;
  logic              seen_busy;

  byte_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_valid),
    .pop   (pop),
    .din   (rx_data),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next state
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:      if (!fifo_empty && spi_ready)     state_next = ST_LAUNCH;
      ST_LAUNCH:                                      state_next = ST_WAIT_SPI;
      ST_WAIT_SPI:  if (spi_done)                     state_next = ST_SEND;
      ST_SEND:      if (uart_tx_ready)                state_next = ST_WAIT_UART;
      // Transmit is finished only once ready has dropped and come back.
      ST_WAIT_UART: if (seen_busy && uart_tx_ready)   state_next = ST_IDLE;
      default:                                        state_next = ST_IDLE;
    endcase
  end

  // Outputs (decoded here, registered below so start pulses are glitch-free)
  always_comb begin
    pop          = (state == ST_IDLE) && !fifo_empty && spi_ready;
    load_rx      = (state == ST_WAIT_SPI) && spi_done;
    spi_start_d  = pop;
    uart_start_d = (state == ST_SEND) && uart_tx_ready;
    drop         = rx_valid && fifo_full && !pop;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      spi_start     <= 1'b0;
      uart_tx_start <= 1'b0;
      spi_tx_data   <= '0;
      uart_tx_data  <= '0;
      overflow      <= 1'b0;
      seen_busy     <= 1'b0;
    end else begin
      spi_start     <= spi_start_d;
      uart_tx_start <= uart_start_d;
      if (pop)     spi_tx_data  <= fifo_head;
      if (load_rx) uart_tx_data <= spi_rx_data;
      // A drop in the same cycle as a clear keeps the flag set.
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
      if (state != ST_WAIT_UART) seen_busy <= 1'b0;
      else if (!uart_tx_ready)   seen_busy <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_spi_bridge.sv
// Directed bench for uart_spi_bridge with simple SPI and UART responder
// models. The SPI model answers each byte with byte ^ 8'h99.
module tb_uart_spi_bridge;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              spi_ready;
  logic              spi_start;
  logic [DATA_W-1:0] spi_tx_data;
  logic              spi_done = 1'b0;
  logic [DATA_W-1:0] spi_rx_data = '0;
  logic              uart_tx_ready;
  logic              uart_tx_start;
  logic [DATA_W-1:0] uart_tx_data;
  logic              ovf_clr;
  logic              overflow;
  logic [$clog2(DEPTH):0] fifo_count;

  int n_cmp = 0;
  int n_err = 0;

  uart_spi_bridge #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .spi_ready     (spi_ready),
    .spi_start     (spi_start),
    .spi_tx_data   (spi_tx_data),
    .spi_done      (spi_done),
    .spi_rx_data   (spi_rx_data),
    .uart_tx_ready (uart_tx_ready),
    .uart_tx_start (uart_tx_start),
    .uart_tx_data  (uart_tx_data),
    .ovf_clr       (ovf_clr),
    .overflow      (overflow),
    .fifo_count    (fifo_count)
  );

  always #5 clk = ~clk;

  // SPI responder: busy for spi_lat cycles after a start, then one done pulse.
  logic spi_en = 1'b0;
  int   spi_lat = 8;
  logic spi_busy = 1'b0;
  int   spi_cnt = 0;
  assign spi_ready = spi_en && !spi_busy;

  always @(posedge clk) begin
    spi_done <= 1'b0;
    if (spi_busy) begin
      if (spi_cnt <= 1) begin
        spi_busy    <= 1'b0;
        spi_done    <= 1'b1;
        spi_rx_data <= spi_tx_data ^ 8'h99;
      end else begin
        spi_cnt <= spi_cnt - 1;
      end
    end else if (spi_start) begin
      spi_busy <= 1'b1;
      spi_cnt  <= spi_lat;
    end
  end

  // UART responder: not ready for uart_lat cycles after a start.
  int   uart_lat = 5;
  logic uart_busy = 1'b0;
  int   uart_cnt = 0;
  assign uart_tx_ready = !uart_busy;

  always @(posedge clk) begin
    if (uart_busy) begin
      if (uart_cnt <= 1) uart_busy <= 1'b0;
      else               uart_cnt  <= uart_cnt - 1;
    end else if (uart_tx_start) begin
      uart_busy <= 1'b1;
      uart_cnt  <= uart_lat;
    end
  end

  // Logs of launched SPI bytes and transmitted UART bytes.
  logic [7:0] spi_log[$];
  logic [7:0] uart_log[$];
  always @(posedge clk) begin
    if (spi_start)     spi_log.push_back(spi_tx_data);
    if (uart_tx_start) uart_log.push_back(uart_tx_data);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int n_exp, input int budget);
    int k;
    k = 0;
    while (uart_log.size() < n_exp && k < budget) begin
      tick();
      k++;
    end
    chk(tag, uart_log.size(), n_exp);
    repeat (12) tick();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_spi_start"},  spi_start,     1'b0);
    chk({tag, "_uart_start"}, uart_tx_start, 1'b0);
    chk({tag, "_spi_tx"},     spi_tx_data,   8'h00);
    chk({tag, "_uart_tx"},    uart_tx_data,  8'h00);
    chk({tag, "_count"},      fifo_count,    3'd0);
    chk({tag, "_ovf"},        overflow,      1'b0);
  endtask

  logic [7:0] exp_order [5];

  initial begin
    reset    = 1'b1;
    rx_data  = '0;
    rx_valid = 1'b0;
    ovf_clr  = 1'b0;
    repeat (2) tick();
    chk_reset_outputs("rst");
    reset = 1'b0;
    tick();

    // Single byte: A5 out on SPI at N+2, reply 3C out on UART.
    spi_en  = 1'b1;
    push(8'hA5);
    chk("single_cnt1",     fifo_count, 3'd1);
    chk("single_nostart",  spi_start,  1'b0);
    tick();
    chk("single_start_n2", spi_start,   1'b1);
    chk("single_spi_tx",   spi_tx_data, 8'hA5);
    chk("single_cnt0",     fifo_count,  3'd0);
    tick();
    chk("single_pulse1",   spi_start,   1'b0);
    wait_drain("single_drain", 1, 100);
    chk("single_nspi",     spi_log.size(), 1);
    chk("single_uart_log", uart_log[0], 8'h3C);
    chk("single_uart_tx",  uart_tx_data, 8'h3C);

    // Overflow: SPI held off, 5 pushes into 4 entries.
    spi_log.delete();
    uart_log.delete();
    spi_en = 1'b0;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44); push(8'h55);
    chk("ovf_cnt",   fifo_count, 3'd4);
    chk("ovf_set",   overflow,   1'b1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_clr",   overflow,   1'b0);
    // Clear coincident with another drop: set wins.
    rx_data  = 8'h66;
    rx_valid = 1'b1;
    ovf_clr  = 1'b1;
    tick();
    rx_valid = 1'b0;
    ovf_clr  = 1'b0;
    chk("ovf_setwins", overflow,   1'b1);
    chk("ovf_cnt2",    fifo_count, 3'd4);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_clr2",    overflow,   1'b0);

    // Full FIFO, push and pop in the same cycle.
    rx_data  = 8'h77;
    rx_valid = 1'b1;
    spi_en   = 1'b1;
    tick();
    rx_valid = 1'b0;
    chk("pp_cnt",    fifo_count,  3'd4);
    chk("pp_ovf",    overflow,    1'b0);
    chk("pp_start",  spi_start,   1'b1);
    chk("pp_spi_tx", spi_tx_data, 8'h11);
    wait_drain("pp_drain", 5, 400);
    exp_order = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h77};
    chk("pp_nspi", spi_log.size(), 5);
    for (int i = 0; i < 5; i++) chk($sformatf("pp_order%0d", i), spi_log[i], exp_order[i]);
    chk("pp_last_uart", uart_log[4], 8'hEE);
    chk("pp_ovf_end",   overflow,    1'b0);
    chk("pp_cnt_end",   fifo_count,  3'd0);

    // Pointer wrap with fast responders: 0x01..0x08.
    spi_log.delete();
    uart_log.delete();
    spi_lat  = 1;
    uart_lat = 1;
    for (int i = 1; i <= 8; i++) begin
      push(8'(i));
      repeat (4) tick();
    end
    wait_drain("wrap_drain", 8, 200);
    chk("wrap_nspi", spi_log.size(), 8);
    for (int i = 0; i < 8; i++) chk($sformatf("wrap_spi%0d", i), spi_log[i], 8'(i + 1));
    chk("wrap_uart7", uart_log[7], 8'h91);
    chk("wrap_ovf",   overflow,    1'b0);

    // Reset during WAIT_SPI, with a second byte still queued.
    spi_log.delete();
    uart_log.delete();
    spi_lat  = 8;
    uart_lat = 5;
    push(8'h5A);
    push(8'h6B);
    repeat (3) tick();
    chk("mid_nspi", spi_log.size(), 1);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_outputs("mid_rst");
    repeat (2) tick();
    reset = 1'b0;
    repeat (30) tick();
    chk("mid_no_spi",  spi_log.size(),  1);
    chk("mid_no_uart", uart_log.size(), 0);
    push(8'hC3);
    wait_drain("mid_drain", 1, 100);
    chk("mid_spi_new",  spi_log[1],  8'hC3);
    chk("mid_uart_new", uart_log[0], 8'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_spi_bridge.md
UART_SPI_BRIDGE -- requirements
Module: uart_spi_bridge

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter DATA_W, default 8, byte width.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 rx_data  in  DATA_W  byte from UART receiver.
REQ-007 rx_valid  in  1  one-cycle pulse; rx_data valid that cycle.
REQ-008 spi_ready  in  1  SPI engine idle, may accept spi_start.
REQ-009 spi_start  out  1  one-cycle pulse launching an SPI transfer.
REQ-010 spi_tx_data  out  DATA_W  byte to shift out on MOSI, held stable from spi_start until spi_done.
REQ-011 spi_done  in  1  one-cycle pulse; transfer complete, spi_rx_data valid that cycle.
REQ-012 spi_rx_data  in  DATA_W  byte captured from MISO.
REQ-013 uart_tx_ready  in  1  UART transmitter idle.
REQ-014 uart_tx_start  out  1  one-cycle pulse launching a UART transmit.
REQ-015 uart_tx_data  out  DATA_W  byte to transmit, held stable from uart_tx_start until the next pop.
REQ-016 ovf_clr  in  1  synchronous clear of overflow.
REQ-017 overflow  out  1  sticky: a byte was dropped on a full FIFO.
REQ-018 fifo_count  out  $clog2(DEPTH)+1  current occupancy.

Function
REQ-019 FIFO: circular buffer, write/read pointers wrap modulo DEPTH; count 0..DEPTH.
REQ-020 Push on rx_valid when count<DEPTH; push when count==DEPTH drops the byte, leaves the FIFO unchanged, and sets overflow.
REQ-021 A push and a pop in the same cycle leave count unchanged; when count==DEPTH, a same-cycle pop frees space and the push is accepted, with no overflow.
REQ-022 FSM states: IDLE, LAUNCH, WAIT_SPI, SEND, WAIT_UART.
REQ-023 IDLE->LAUNCH when count>0 and spi_ready; pops the head into spi_tx_data register.
REQ-024 LAUNCH: spi_start=1 for exactly this cycle; ->WAIT_SPI unconditionally.
REQ-025 WAIT_SPI: on spi_done, latch spi_rx_data into uart_tx_data; ->SEND.
REQ-026 SEND: wait for uart_tx_ready; then uart_tx_start=1 for one cycle; ->WAIT_UART.
REQ-027 WAIT_UART: ->IDLE when uart_tx_ready is low for at least one cycle and then high again (transmit finished).
REQ-028 Latency: rx_valid at cycle N into an empty FIFO with spi_ready high -> spi_start high in cycle N+2.
REQ-029 spi_done outside WAIT_SPI SHALL be ignored; spi_ready is only sampled in IDLE.
REQ-030 ovf_clr and a simultaneous overflow event: the set wins.
REQ-031 Outputs spi_start and uart_tx_start SHALL be registered (no combinational path from inputs).

Reset
REQ-032 reset SHALL asynchronously force: FSM=IDLE, pointers=0, count=0, overflow=0, spi_start=0, uart_tx_start=0, spi_tx_data=0, uart_tx_data=0.
REQ-033 Reset mid-transfer SHALL abandon the byte in flight; FIFO contents are discarded, with no start pulse after release until a new push.

Structure
REQ-034 Shared package uart_spi_pkg SHALL hold the FSM state enum and the DATA_W default.
REQ-035 The FIFO SHALL be the single sub-module byte_fifo (push/pop/full/empty/count); the FSM lives in uart_spi_bridge.

Verification
REQ-036 Single byte 0xA5 pushed, model SPI returns 0x3C after 8 cycles -> one spi_start with spi_tx_data=0xA5 at N+2; one uart_tx_start with uart_tx_data=0x3C.
REQ-037 DEPTH=4, spi_ready held low, push 5 bytes -> fifo_count=4, overflow=1, fifth byte absent; ovf_clr -> overflow=0.
REQ-038 Full FIFO, push and pop in the same cycle -> count stays 4, overflow stays 0, the pushed byte is delivered last in order.
REQ-039 Push 0x01..0x08 with DEPTH=4 and fast SPI/UART models -> SPI sees 0x01..0x08 in order, showing pointer wrap.
REQ-040 Assert reset during WAIT_SPI -> all outputs 0 immediately; no uart_tx_start after release; the next push is processed normally.
